// File: rtl/int_div_seq.sv
// Iterative radix-2 restoring divider (RV64M DIV/DIVU/REM/REMU), one op at a time.
// Define DIV_FAST_SPECIAL_EN to resolve divide-by-zero, signed overflow and |a|<|b| early.
module int_div_seq #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_signed,
    input  logic            in_rem,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, SETUP, ITER, FIXUP, DONE} state_t;
    state_t state, state_nx;

    logic [XLEN-1:0] op_a, op_b;
    logic            op_signed, op_rem;
    logic            setup_ph;
    logic [XLEN-1:0] quo, dvs, prem;
    logic [CW-1:0]   cnt;
    logic            q_neg, r_neg, div0, ovf;

    logic            a_neg, b_neg, is_div0, is_ovf;
    logic [XLEN-1:0] a_abs, b_abs;
    logic [XLEN:0]   shifted, diff;
    logic [XLEN-1:0] q_fix, r_fix, fix_res;
    logic            fast_hit;
    logic [XLEN-1:0] fast_res;

    // Abs values are registered in the first SETUP cycle so the magnitude
    // compare of the second cycle does not sit behind two negators.
    always_comb begin
        a_neg   = op_signed & op_a[XLEN-1];
        b_neg   = op_signed & op_b[XLEN-1];
        a_abs   = a_neg ? -op_a : op_a;
        b_abs   = b_neg ? -op_b : op_b;
        is_div0 = (op_b == '0);
        is_ovf  = op_signed && (op_a == MIN_NEG) && (op_b == '1);
        shifted = {prem, quo[XLEN-1]};
        diff    = shifted - {1'b0, dvs};
    end

    always_comb begin
        q_fix = q_neg ? -quo : quo;
        r_fix = r_neg ? -prem : prem;
        if (div0) begin
            q_fix = '1;
            r_fix = op_a;
        end else if (ovf) begin
            q_fix = op_a;
            r_fix = '0;
        end
        fix_res = op_rem ? r_fix : q_fix;
    end

`ifdef DIV_FAST_SPECIAL_EN
    logic [XLEN-1:0] fast_q, fast_r;
    always_comb begin
        fast_hit = div0 | ovf | (quo < dvs);
        fast_q   = div0 ? '1 : (ovf ? op_a : '0);
        fast_r   = ovf ? '0 : op_a;
        fast_res = op_rem ? fast_r : fast_q;
    end
`else
    always_comb begin
        fast_hit = 1'b0;
        fast_res = '0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = SETUP;
            SETUP:   if (setup_ph) state_nx = fast_hit ? DONE : ITER;
            ITER:    if (cnt == '0) state_nx = FIXUP;
            FIXUP:   state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            out_data <= '0;
            setup_ph <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a      <= in_a;
                        op_b      <= in_b;
                        op_signed <= in_signed;
                        op_rem    <= in_rem;
                    end
                    setup_ph <= 1'b0;
                end
                SETUP: begin
                    if (!setup_ph) begin
                        quo      <= a_abs;
                        dvs      <= b_abs;
                        prem     <= '0;
                        q_neg    <= a_neg ^ b_neg;
                        r_neg    <= a_neg;
                        div0     <= is_div0;
                        ovf      <= is_ovf;
                        setup_ph <= 1'b1;
                    end else begin
                        cnt      <= CW'(XLEN-1);
                        setup_ph <= 1'b0;
                        if (fast_hit) out_data <= fast_res;
                    end
                end
                ITER: begin
                    // Trial subtract; the borrow bit decides keep/restore.
                    if (!diff[XLEN]) begin
                        prem <= diff[XLEN-1:0];
                        quo  <= {quo[XLEN-2:0], 1'b1};
                    end else begin
                        prem <= shifted[XLEN-1:0];
                        quo  <= {quo[XLEN-2:0], 1'b0};
                    end
                    cnt <= cnt - 1'b1;
                end
                FIXUP:   out_data <= fix_res;
                default: ;
            endcase
        end
    end

endmodule
